// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader.
// State encoding and output buffer depth.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int FifoDepth = 2;
    localparam int OccWidth  = $clog2(FifoDepth + 1);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output buffer; the head entry lives in its own register
// so head_data/head_last leave the block straight from flops.
module stream_fifo2
    import ram_stream_pkg::*;
#(
    parameter int DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 push_last,
    input  logic                 pop,
    output logic                 head_valid,
    output logic [DataWidth-1:0] head_data,
    output logic                 head_last,
    output logic [OccWidth-1:0]  occupancy
);

    logic [DataWidth-1:0] tail_data;
    logic                 tail_last;
    logic [OccWidth-1:0]  occ_q;
    logic                 pop_ok;

    assign pop_ok     = pop && (occ_q != '0);
    assign head_valid = (occ_q != '0);
    assign occupancy  = occ_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ_q     <= '0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (occ_q == '0) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                    occ_q <= occ_q + OccWidth'(1);
                end
                2'b01: begin
                    if (occ_q == OccWidth'(FifoDepth)) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                    end
                    occ_q <= occ_q - OccWidth'(1);
                end
                2'b11: begin
                    if (occ_q == OccWidth'(1)) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks an address range on the RAM read port and streams the words out.
// Define RAM_STREAM_READER_WRAP_EN to wrap addresses at DataDepth.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int DataWidth  = 8,
    parameter int AddrWidth  = 10,
    parameter int DataDepth  = 1024,
    parameter int CountWidth = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AddrWidth-1:0]  cmd_addr,
    input  logic [CountWidth-1:0] cmd_count,
    output logic                  ram_read_en,
    output logic [AddrWidth-1:0]  ram_read_addr,
    input  logic [DataWidth-1:0]  ram_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DataWidth-1:0]  out_data,
    output logic                  out_last,
    output logic                  done
);

`ifdef RAM_STREAM_READER_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    localparam logic [AddrWidth-1:0] LastAddr =
        WrapEn ? AddrWidth'(DataDepth - 1) : '1;

    state_e                state_q;
    state_e                state_d;
    logic [AddrWidth-1:0]  addr_q;
    logic [AddrWidth-1:0]  addr_next;
    logic [CountWidth-1:0] remain_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  cmd_fire;
    logic                  issue;
    logic                  final_issue;
    logic                  pop;
    logic [OccWidth-1:0]   occ;
    logic [2:0]            pend;

    assign cmd_ready = reset_n && (state_q == IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign pop       = out_valid && out_ready;
    assign done      = reset_n && (state_q == DONE);

    // Issue is decided from registered occupancy and this cycle's pop,
    // which lets a 2-entry buffer sustain one word per cycle.
    assign pend        = 3'(occ) + 3'(inflight_q) - 3'(pop);
    assign issue       = reset_n && (state_q == RUN)
                         && (pend < 3'(FifoDepth));
    assign final_issue = issue && (remain_q == CountWidth'(1));

    assign addr_next     = (addr_q == LastAddr)
                           ? '0 : addr_q + AddrWidth'(1);
    assign ram_read_en   = issue;
    assign ram_read_addr = addr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = (cmd_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (final_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= final_issue;
            if (cmd_fire) begin
                addr_q   <= cmd_addr;
                remain_q <= cmd_count;
            end else if (issue) begin
                addr_q   <= addr_next;
                remain_q <= remain_q - CountWidth'(1);
            end
        end
    end

    stream_fifo2 #(
        .DataWidth(DataWidth)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (ram_read_data),
        .push_last (inflight_last_q),
        .pop       (pop),
        .head_valid(out_valid),
        .head_data (out_data),
        .head_last (out_last),
        .occupancy (occ)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model plus a queue-based scoreboard
// of expected read addresses and output words per command.
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int CW = 11;
`ifdef RAM_STREAM_READER_WRAP_EN
    localparam int DEPTH      = 1000;
    localparam int WRAP_START = 998;
`else
    localparam int DEPTH      = 1024;
    localparam int WRAP_START = 1022;
`endif
    localparam int MOD = DEPTH;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [CW-1:0] cmd_count;
    logic          ram_read_en;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_read_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;

    ram_stream_reader #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .DataDepth (DEPTH),
        .CountWidth(CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_count    (cmd_count),
        .ram_read_en  (ram_read_en),
        .ram_read_addr(ram_read_addr),
        .ram_read_data(ram_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];

    always @(posedge clk) begin
        if (ram_read_en) ram_read_data <= mem[ram_read_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int hs_q[$];
    int fv_q[$];
    int done_q[$];
    bit await_fv;
    bit hold_pending;
    bit prev_done;
    logic [DW-1:0] held_data;
    logic held_last;
    int issued;
    int popped;
    int vcount;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_addr_q.delete();
        hs_q.delete();
        fv_q.delete();
        done_q.delete();
        await_fv = 1'b0;
    endtask

    task automatic reset_model();
        clear_model();
        hold_pending = 1'b0;
        prev_done = 1'b0;
        issued = 0;
        popped = 0;
        vcount = 0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_read_en"}, ram_read_en, 0);
        chk({tag, "_read_addr"}, ram_read_addr, 0);
    endtask

    // One clock of observation: sample at negedge, return at posedge+1.
    task automatic run_cycle();
        logic [8:0] e;
        int a;
        int pop_now;
        @(negedge clk);
        pop_now = (out_valid && out_ready) ? 1 : 0;
        if (cmd_valid && cmd_ready) begin
            for (int k = 0; k < int'(cmd_count); k++) begin
                a = (int'(cmd_addr) + k) % MOD;
                exp_addr_q.push_back(AW'(a));
                exp_q.push_back({k == int'(cmd_count) - 1, mem[a]});
            end
            hs_q.push_back(cyc);
            await_fv = 1'b1;
        end
        if (ram_read_en) begin
            chk("read_expected", 32'(exp_addr_q.size() != 0), 1);
            if (exp_addr_q.size() != 0)
                chk("read_addr", ram_read_addr, exp_addr_q.pop_front());
            chk("read_credit", 32'(issued + 1 - popped - pop_now <= 2), 1);
            issued++;
        end
        if (out_valid) begin
            vcount++;
            if (await_fv) begin
                fv_q.push_back(cyc);
                await_fv = 1'b0;
            end
        end
        if (hold_pending) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held_data);
            chk("hold_last", out_last, held_last);
        end
        if (pop_now != 0) begin
            chk("word_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[7:0]);
                chk("out_last", out_last, e[8]);
            end
            popped++;
        end
        hold_pending = out_valid && !out_ready;
        held_data = out_data;
        held_last = out_last;
        if (done) begin
            done_q.push_back(cyc);
            chk("done_after_drain", exp_q.size(), 0);
            chk("done_pulse_width", prev_done, 0);
        end
        prev_done = done;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: toggling, 2: random
    task automatic do_cmd(input int addr, input int count,
                          input int mode, input int bound);
        int n;
        int d0;
        int h0;
        n = 0;
        d0 = done_q.size();
        h0 = hs_q.size();
        cmd_valid = 1'b1;
        cmd_addr = AW'(addr);
        cmd_count = CW'(count);
        while (done_q.size() == d0 && n < bound) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (n % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            run_cycle();
            if (hs_q.size() != h0) cmd_valid = 1'b0;
            n++;
        end
        cmd_valid = 1'b0;
        chk("cmd_completed", done_q.size() - d0, 1);
    endtask

    initial begin
        int n;
        int i0;
        int p0;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_count = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
        reset_model();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        check_quiet("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);
        check_quiet("rel");
        @(posedge clk);
        #1;

        // basic: 4 words at full rate
        clear_model();
        i0 = issued;
        do_cmd(32'h010, 4, 0, 40);
        chk("basic_reads", issued - i0, 4);
        if (hs_q.size() == 1 && fv_q.size() == 1 && done_q.size() == 1) begin
            chk("basic_first_valid", fv_q[0] - hs_q[0], 3);
            chk("basic_done_cycle", done_q[0] - hs_q[0], 7);
        end else begin
            chk("basic_events", 32'(fv_q.size()), 1);
        end

        // backpressure with alternating ready
        clear_model();
        p0 = popped;
        do_cmd(0, 8, 1, 200);
        chk("bp_words", popped - p0, 8);
        chk("bp_queue_empty", exp_q.size(), 0);

        // zero count
        clear_model();
        i0 = issued;
        do_cmd(32'h155, 0, 0, 20);
        chk("zero_reads", issued - i0, 0);
        chk("zero_no_valid", fv_q.size(), 0);
        if (hs_q.size() == 1 && done_q.size() == 1)
            chk("zero_done_cycle", done_q[0] - hs_q[0], 1);
        else
            chk("zero_events", 32'(done_q.size()), 1);

        // address wrap
        clear_model();
        i0 = issued;
        do_cmd(WRAP_START, 4, 0, 40);
        chk("wrap_reads", issued - i0, 4);
        chk("wrap_addr_q_empty", exp_addr_q.size(), 0);

        // back-to-back: second command offered while first runs
        clear_model();
        cmd_valid = 1'b1;
        cmd_addr = AW'(32'h200);
        cmd_count = CW'(6);
        out_ready = 1'b1;
        n = 0;
        while (hs_q.size() < 1 && n < 20) begin
            run_cycle();
            n++;
        end
        cmd_addr = AW'(32'h2F0);
        cmd_count = CW'(5);
        while (done_q.size() < 2 && n < 100) begin
            run_cycle();
            if (hs_q.size() == 2) cmd_valid = 1'b0;
            n++;
        end
        cmd_valid = 1'b0;
        chk("b2b_dones", done_q.size(), 2);
        if (hs_q.size() == 2 && done_q.size() == 2 && fv_q.size() == 2) begin
            chk("b2b_second_hs", hs_q[1] - done_q[0], 1);
            chk("b2b_first_lat", fv_q[0] - hs_q[0], 3);
            chk("b2b_second_lat", fv_q[1] - hs_q[1], 3);
        end else begin
            chk("b2b_handshakes", hs_q.size(), 2);
        end

        // reset in the middle of a stream
        clear_model();
        cmd_valid = 1'b1;
        cmd_addr = AW'(32'h100);
        cmd_count = CW'(16);
        out_ready = 1'b1;
        p0 = popped;
        n = 0;
        while (popped - p0 < 2 && n < 40) begin
            run_cycle();
            if (hs_q.size() != 0) cmd_valid = 1'b0;
            n++;
        end
        cmd_valid = 1'b0;
        chk("mid_two_words", popped - p0, 2);
        out_ready = 1'b0;
        repeat (3) run_cycle();
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        reset_model();
        @(negedge clk);
        chk("mid_rel_cmd_ready", cmd_ready, 1);
        check_quiet("mid_rel");
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) run_cycle();
        chk("mid_no_stale", vcount, 0);

        // randomized commands over random RAM contents
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
        for (int t = 0; t < 10; t++) begin
            clear_model();
            p0 = popped;
            n = $urandom_range(0, 20);
            do_cmd($urandom_range(0, MOD - 1), n, 2, 400);
            chk("rand_words", popped - p0, n);
            chk("rand_queue_empty", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
